// File: rtl/uart_word_tx.sv
// Word-to-byte serializer for the UART debug link: FIFO-buffered words sent LSB byte first.
// Optional trailing XOR checksum byte per word when UART_WORD_TX_CHECKSUM_EN is defined.
module uart_word_tx #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NB_WORD-1:0]         i_word,
    input  logic                       i_word_valid,
    output logic                       o_word_ready,
    output logic [NB_BYTE-1:0]         o_tx_data,
    output logic                       o_tx_start,
    input  logic                       i_tx_done_pulse,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);

    localparam int NB_CNT  = $clog2(DEPTH + 1);
    localparam int NB_PTR  = $clog2(DEPTH);
    localparam int N_BYTES = NB_WORD / NB_BYTE;
    localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

`ifdef UART_WORD_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, WAIT, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
`endif

    state_t               state, state_nxt;
    logic [NB_WORD-1:0]   mem [DEPTH];
    logic [NB_PTR-1:0]    wr_ptr, rd_ptr;
    logic [NB_CNT-1:0]    count;
    logic                 push, pop;
    logic [NB_WORD-1:0]   shift, shift_nxt;
    logic [NB_BCNT-1:0]   bcnt, bcnt_nxt;
    logic [NB_BYTE-1:0]   data_nxt;
    logic                 start_nxt;
`ifdef UART_WORD_TX_CHECKSUM_EN
    logic [NB_BYTE-1:0]   csum, csum_nxt;
    logic                 chk_sent, chk_sent_nxt;

    function automatic logic [NB_BYTE-1:0] xor_bytes(input logic [NB_WORD-1:0] w);
        logic [NB_BYTE-1:0] x;
        x = '0;
        for (int i = 0; i < N_BYTES; i++) x ^= w[i*NB_BYTE +: NB_BYTE];
        return x;
    endfunction
`endif

    // Ready comes from the registered count only, so a full FIFO refuses a push even while popping.
    assign o_word_ready = (count < NB_CNT'(DEPTH));
    assign push         = i_word_valid && o_word_ready;
    assign o_fifo_count = count;
    assign o_busy       = (state != IDLE) || (count != '0);

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr] <= i_word;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + NB_PTR'(1);
            if (pop)  rd_ptr <= rd_ptr + NB_PTR'(1);
            case ({push, pop})
                2'b10:   count <= count + NB_CNT'(1);
                2'b01:   count <= count - NB_CNT'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            shift      <= '0;
            bcnt       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum       <= '0;
            chk_sent   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bcnt       <= bcnt_nxt;
            o_tx_data  <= data_nxt;
            o_tx_start <= start_nxt;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum       <= csum_nxt;
            chk_sent   <= chk_sent_nxt;
`endif
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        bcnt_nxt  = bcnt;
        data_nxt  = o_tx_data;
        start_nxt = 1'b0;
        pop       = 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
        csum_nxt     = csum;
        chk_sent_nxt = chk_sent;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    bcnt_nxt  = NB_BCNT'(N_BYTES - 1);
`ifdef UART_WORD_TX_CHECKSUM_EN
                    csum_nxt     = xor_bytes(mem[rd_ptr]);
                    chk_sent_nxt = 1'b0;
`endif
                    state_nxt = SEND;
                end
            end
            SEND: begin
                data_nxt  = shift[NB_BYTE-1:0];
                start_nxt = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (i_tx_done_pulse) begin
                    if (bcnt == '0) begin
`ifdef UART_WORD_TX_CHECKSUM_EN
                        state_nxt = chk_sent ? IDLE : CHK;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        shift_nxt = shift >> NB_BYTE;
                        bcnt_nxt  = bcnt - NB_BCNT'(1);
                        state_nxt = SEND;
                    end
                end
            end
`ifdef UART_WORD_TX_CHECKSUM_EN
            CHK: begin
                data_nxt     = csum;
                start_nxt    = 1'b1;
                chk_sent_nxt = 1'b1;
                state_nxt    = WAIT;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule
